bus_arb: RTL
============

BUS_ARB -- requirements
Module: bus_arb

Interface
REQ-001 Parameter: STARVE_MAX, default 4, maximum consecutive load/store grants while a fetch request waits.
REQ-002 clk  in  1  single core clock; all state on rising edge.
REQ-003 rst  in  1  reset, asynchronous, active-high.
REQ-004 if_req  in  1  instruction-fetch request, held until if_ack.
REQ-005 if_addr  in  32  fetch address.
REQ-006 if_ack  out  1  fetch complete, one-cycle pulse.
REQ-007 if_rdata  out  32  fetch data, valid while if_ack=1.
REQ-008 ls_req  in  1  load/store request, held until ls_ack.
REQ-009 ls_we  in  1  1=store, 0=load.
REQ-010 ls_addr  in  32  load/store address.
REQ-011 ls_wdata  in  32  store data.
REQ-012 ls_ack  out  1  load/store complete, one-cycle pulse.
REQ-013 ls_rdata  out  32  load data, valid while ls_ack=1.
REQ-014 mem_req  out  1  memory request, registered.
REQ-015 mem_we  out  1  memory write enable, registered.
REQ-016 mem_addr  out  32  memory address, registered.
REQ-017 mem_wdata  out  32  memory write data, registered.
REQ-018 mem_ack  in  1  memory completion; mem_rdata valid the same cycle.
REQ-019 mem_rdata  in  32  memory read data.
REQ-020 hold2ctrl  out  1  pipeline stall request to ctrl.

Function
REQ-021 States: IDLE, IF_BUSY, LS_BUSY.
REQ-022 IDLE, no request: stay in IDLE with mem_req=0.
REQ-023 IDLE, request present: arbitrate; next cycle enter IF_BUSY or LS_BUSY with mem_req=1; grant-to-mem_req latency is exactly 1 cycle.
REQ-024 Priority: LS wins when both request unless starve_cnt==STARVE_MAX, in which case IF wins.
REQ-025 On grant, capture address, we and wdata into the mem_* registers; for IF grants mem_we=0 and mem_wdata=0.
REQ-026 mem_* outputs are stable for the whole BUSY state, independent of requester inputs.
REQ-027 In BUSY with mem_ack=1: the granted port's ack is mem_ack, combinational, same cycle; rdata passes mem_rdata through; next state is IDLE with mem_req=0.
REQ-028 The non-granted port's ack is 0 always; its rdata is 0 when not acked.
REQ-029 Zero-wait memory (mem_ack in the first BUSY cycle): 2 cycles per transfer.
REQ-030 starve_cnt is clog2(STARVE_MAX+1) bits wide.
REQ-031 starve_cnt: +1 on an LS grant while if_req=1, saturating at STARVE_MAX.
REQ-032 starve_cnt: cleared on any IF grant, and on an LS grant while if_req=0.
REQ-033 Requester deasserting req mid-transaction: the transaction still completes and ack still pulses; no abort.
REQ-034 mem_ack in IDLE is ignored; no ack is generated.
REQ-035 hold2ctrl = (ls_req & ~ls_ack) | (if_req & ~if_ack), combinational.

Reset
REQ-036 rst=1 forces, immediately and asynchronously: state=IDLE, starve_cnt=0, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0.
REQ-037 While rst=1: if_ack=0 and ls_ack=0.
REQ-038 Reset mid-transaction abandons it; no ack is issued after reset deasserts.
REQ-039 First arbitration occurs in the first clock edge after rst deasserts.

Structure
REQ-040 Shared package riscv_pkg holds: the state enum {IDLE, IF_BUSY, LS_BUSY}, the STARVE_MAX default, and the 32-bit bus width constant.
REQ-041 Single module, no sub-modules; the starvation counter is an inline register.

Verification
REQ-042 IF-only: if_req=1, if_addr=0x100, mem_ack=1 zero-wait -> mem_req=1 with mem_addr=0x100 the next cycle; if_ack=1 with if_rdata=mem_rdata that cycle; IDLE after.
REQ-043 Contention: if_req=1 and ls_req=1 held continuously, STARVE_MAX=4, zero-wait -> grant order LS,LS,LS,LS,IF,LS...; starve_cnt reaches 4 then clears.
REQ-044 Store: ls_req=1, ls_we=1, ls_addr=0x2000, ls_wdata=0xDEADBEEF, mem_ack delayed 3 cycles -> mem_* stable for 3 cycles; ls_ack pulses exactly once; hold2ctrl=1 until the ack cycle.
REQ-045 Reset mid-op: assert rst during LS_BUSY before mem_ack -> mem_req=0 in the same cycle without waiting for a clock edge; a later mem_ack produces no ls_ack.
REQ-046 Spurious: mem_ack=1 in IDLE -> if_ack=0 and ls_ack=0; state unchanged.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared bus-width, arbiter state encoding and starvation default for the core's memory port.
package riscv_pkg;

    localparam int unsigned XLEN           = 32;
    localparam int unsigned STARVE_MAX_DEF = 4;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        IF_BUSY = 2'd1,
        LS_BUSY = 2'd2
    } arb_state_e;

endpackage

// File: rtl/bus_arb.sv
// Two-requester memory arbiter: load/store has priority, but a waiting fetch wins once
// it has been passed over STARVE_MAX times in a row.
module bus_arb
    import riscv_pkg::*;
#(
    parameter int unsigned STARVE_MAX = STARVE_MAX_DEF
) (
    input  logic            clk,
    input  logic            rst,

    input  logic            if_req,
    input  logic [XLEN-1:0] if_addr,
    output logic            if_ack,
    output logic [XLEN-1:0] if_rdata,

    input  logic            ls_req,
    input  logic            ls_we,
    input  logic [XLEN-1:0] ls_addr,
    input  logic [XLEN-1:0] ls_wdata,
    output logic            ls_ack,
    output logic [XLEN-1:0] ls_rdata,

    output logic            mem_req,
    output logic            mem_we,
    output logic [XLEN-1:0] mem_addr,
    output logic [XLEN-1:0] mem_wdata,
    input  logic            mem_ack,
    input  logic [XLEN-1:0] mem_rdata,

    output logic            hold2ctrl
);

    localparam int unsigned CNT_W = $clog2(STARVE_MAX + 1);

    arb_state_e        state_q;
    arb_state_e        state_d;
    logic [CNT_W-1:0]  starve_q;
    logic [CNT_W-1:0]  starve_d;
    logic              mem_req_d;
    logic              mem_we_d;
    logic [XLEN-1:0]   mem_addr_d;
    logic [XLEN-1:0]   mem_wdata_d;
    logic              starved;

    assign starved = (starve_q == CNT_W'(STARVE_MAX));

    // State and registered memory-side request
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            starve_q  <= '0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            state_q   <= state_d;
            starve_q  <= starve_d;
            mem_req   <= mem_req_d;
            mem_we    <= mem_we_d;
            mem_addr  <= mem_addr_d;
            mem_wdata <= mem_wdata_d;
        end
    end

    // Arbitration and next-state; mem_* only change on a grant or on completion
    always_comb begin
        state_d     = state_q;
        starve_d    = starve_q;
        mem_req_d   = mem_req;
        mem_we_d    = mem_we;
        mem_addr_d  = mem_addr;
        mem_wdata_d = mem_wdata;
        case (state_q)
            IDLE: begin
                if (ls_req && !(if_req && starved)) begin
                    state_d     = LS_BUSY;
                    mem_req_d   = 1'b1;
                    mem_we_d    = ls_we;
                    mem_addr_d  = ls_addr;
                    mem_wdata_d = ls_wdata;
                    if (if_req) begin
                        starve_d = starved ? starve_q : starve_q + CNT_W'(1);
                    end else begin
                        starve_d = '0;
                    end
                end else if (if_req) begin
                    state_d     = IF_BUSY;
                    mem_req_d   = 1'b1;
                    mem_we_d    = 1'b0;
                    mem_addr_d  = if_addr;
                    mem_wdata_d = '0;
                    starve_d    = '0;
                end
            end
            IF_BUSY, LS_BUSY: begin
                if (mem_ack) begin
                    state_d   = IDLE;
                    mem_req_d = 1'b0;
                end
            end
            default: begin
                state_d   = IDLE;
                mem_req_d = 1'b0;
            end
        endcase
    end

    // Completion is forwarded straight from memory to the owning requester
    assign if_ack    = (state_q == IF_BUSY) && mem_ack && !rst;
    assign ls_ack    = (state_q == LS_BUSY) && mem_ack && !rst;
    assign if_rdata  = if_ack ? mem_rdata : '0;
    assign ls_rdata  = ls_ack ? mem_rdata : '0;
    assign hold2ctrl = (ls_req && !ls_ack) || (if_req && !if_ack);

endmodule
